// File: rtl/word_fifo.sv
// Show-ahead word FIFO with registered flags, head word and sticky overflow.
// Optional even-parity output on the head word when WORD_FIFO_PARITY_EN is defined.
module word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef WORD_FIFO_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_overflow;

  logic             w_wr;
  logic             w_rd;
  logic [AW-1:0]    w_wr_ptr_nxt;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_data_nxt;

  assign w_wr = in_valid && r_in_ready;
  assign w_rd = r_out_valid && out_ready;

  // Next-state values; the head word is pre-computed so out_data stays a register.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr + AW'(w_wr);
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_rd);
    w_count_nxt  = r_count + CW'(w_wr) - CW'(w_rd);
    w_data_nxt   = '0;
    if (w_count_nxt != '0) begin
      // The word being written becomes the head when it lands at the new read pointer.
      if (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) begin
        w_data_nxt = in_data;
      end else begin
        w_data_nxt = r_mem[w_rd_ptr_nxt];
      end
    end
  end

  // Storage array carries no reset; validity is tracked by the count.
  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != CW'(DEPTH));
      r_out_valid <= (w_count_nxt != '0);
      r_out_data  <= w_data_nxt;
      if (in_valid && !r_in_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign count     = r_count;
  assign overflow  = r_overflow;

`ifdef WORD_FIFO_PARITY_EN
  logic r_parity;

  // Parity of the next head word; zero data when empty gives zero parity.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= ^w_data_nxt;
    end
  end

  assign out_parity = r_parity;
`endif

endmodule

// File: tb/tb_word_fifo.sv
// Directed self-checking bench for word_fifo (WIDTH=32, DEPTH=4).
module tb_word_fifo;

  logic        clock;
  logic        clear_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic        overflow;
`ifdef WORD_FIFO_PARITY_EN
  logic        out_parity;
`endif

  int n_cmp = 0;
  int n_err = 0;

  word_fifo #(.WIDTH(32), .DEPTH(4)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
`ifdef WORD_FIFO_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b0;

    // Reset held for 3 cycles while offering data
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_count", 64'(count), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
`ifdef WORD_FIFO_PARITY_EN
      check("rst_parity", 64'(out_parity), 64'd0);
`endif
    end

    // Single word, write on first edge after release
    clear_n  = 1'b1;
    in_data  = 32'h0000_4477;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data", 64'(out_data), 64'h4477);
    check("single_count", 64'(count), 64'd1);
    step();
    step();
    check("single_hold_data", 64'(out_data), 64'h4477);
    check("single_hold_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_drain_count", 64'(count), 64'd0);
    check("single_drain_valid", 64'(out_valid), 64'd0);
    check("single_drain_data", 64'(out_data), 64'd0);

    // Fill to full
    for (int i = 1; i <= 4; i++) begin
      in_data  = 32'(i);
      in_valid = 1'b1;
      step();
    end
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_overflow_pre", 64'(overflow), 64'd0);
    check("full_head", 64'(out_data), 64'd1);

    // Offer while full: dropped, overflow sets
    in_data = 32'h5;
    step();
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd4);
    check("ovf_head", 64'(out_data), 64'd1);

    // Full with simultaneous read: read happens, write refused
    in_data   = 32'h55;
    out_ready = 1'b1;
    step();
    check("fullrd_count", 64'(count), 64'd3);
    check("fullrd_in_ready", 64'(in_ready), 64'd1);
    check("fullrd_head", 64'(out_data), 64'd2);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("fullrd_write_count", 64'(count), 64'd4);

    // Drain in order: 2,3,4,55
    out_ready = 1'b1;
    check("drain0", 64'(out_data), 64'h2);
    step();
    check("drain1", 64'(out_data), 64'h3);
    step();
    check("drain2", 64'(out_data), 64'h4);
    step();
    check("drain3", 64'(out_data), 64'h55);
    step();
    check("drain_empty_count", 64'(count), 64'd0);
    check("drain_empty_data", 64'(out_data), 64'd0);
    check("drain_overflow_sticky", 64'(overflow), 64'd1);

    // Streaming through pointer wrap with out_ready high
    for (int i = 0; i < 10; i++) begin
      in_data  = 32'hA0 + 32'(i);
      in_valid = 1'b1;
      step();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data", 64'(out_data), 64'hA0 + 64'(i));
      check("stream_count", 64'(count), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_end_count", 64'(count), 64'd0);
    out_ready = 1'b0;

`ifdef WORD_FIFO_PARITY_EN
    in_data  = 32'h7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("parity_7", 64'(out_parity), 64'd1);
    out_ready = 1'b1;
    in_data   = 32'h3;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("parity_3_data", 64'(out_data), 64'h3);
    check("parity_3", 64'(out_parity), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("parity_empty", 64'(out_parity), 64'd0);
`endif

    // Asynchronous reset mid-operation discards contents
    in_data  = 32'h1234;
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    check("pre_reset_count", 64'(count), 64'd2);
    clear_n = 1'b0;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data", 64'(out_data), 64'd0);
    check("async_rst_overflow", 64'(overflow), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    step();
    clear_n = 1'b1;
    step();
    check("post_reset_count", 64'(count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
